aes_round_ctrl: RTL

Iterative-round sequencer for the AES-128 encryption datapath. Accepts a block/key handshake, sequences the shared round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey plus on-the-fly key expansion) for NUM_ROUNDS cycles, and presents the result under a valid/ready handshake. It generates the state and key register enables, round index, MixColumns bypass for the final round, and the Rcon byte. It carries no 128-bit data itself.

---
 rtl/aes_round_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative-round sequencer for an AES-128 encryption datapath.
// Drives the state/key register enables, the round index, the final-round
// MixColumns bypass and the key-expansion round constant. Holds no block data.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic       ld_state,
  output logic       ld_key,
  output logic       st_en,
  output logic       key_en,
  output logic [3:0] round,
  output logic       mix_bypass,
  output logic [7:0] rcon,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [7:0] RCON_FIRST = 8'h01;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q,  rcon_d;
  logic       accept;

  // GF(2^8) multiply-by-two, used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // State, round index and round constant registers; reset parks in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      rcon_q  <= RCON_FIRST;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // Next-state logic: flush aborts everything, otherwise walk IDLE->ROUND->DONE.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    if (flush) begin
      state_d = S_IDLE;
      round_d = 4'd0;
      rcon_d  = RCON_FIRST;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d = S_ROUND;
            round_d = 4'd1;
            rcon_d  = RCON_FIRST;
          end
        end
        S_ROUND: begin
          if (round_q == LAST_ROUND) begin
            // Round and rcon freeze at the final values while the result waits.
            state_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (accept) begin
              // Back-to-back: the next block loads in the same cycle the result leaves.
              state_d = S_ROUND;
              round_d = 4'd1;
              rcon_d  = RCON_FIRST;
            end else begin
              state_d = S_IDLE;
              round_d = 4'd0;
              rcon_d  = RCON_FIRST;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          round_d = 4'd0;
          rcon_d  = RCON_FIRST;
        end
      endcase
    end
  end

  // Output decode: handshake, datapath enables and status flags.
  always_comb begin
    in_ready   = 1'b0;
    accept     = 1'b0;
    ld_state   = 1'b0;
    ld_key     = 1'b0;
    st_en      = 1'b0;
    key_en     = 1'b0;
    mix_bypass = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = !flush;
      end
      S_ROUND: begin
        busy       = 1'b1;
        st_en      = !flush;
        key_en     = !flush;
        mix_bypass = (round_q == LAST_ROUND);
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // out_ready feeds in_ready combinationally so a block can enter as one leaves.
        in_ready  = out_ready && !flush;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
    accept   = in_valid && in_ready;
    ld_state = accept;
    ld_key   = accept;
  end

  assign round = round_q;
  assign rcon  = rcon_q;

endmodule
